// File: rtl/binoc_local_ni.sv
// binoc_local_ni: local network interface in front of a BiNoC router's local
// input port. Packets from the core are queued in a small injection FIFO,
// HP/LP requests are raised toward the router, and granted packets are
// presented for exactly one cycle on localPacket_0 (HP) / localPacket_1 (LP).
// Two packets leave in one cycle when both grants arrive together.
//
// Build option: define BINOC_NI_TRISTATE_EN to make localPacket_0/1 tristate
// outputs that float ('z) when idle, so they can share bidirectional channel
// nets with other drivers. Without it the idle value is all-zero.
module binoc_local_ni #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_valid,
  output logic              core_ready,
  input  logic [DATA_W-1:0] core_packet,
  input  logic              local_full_0,
  input  logic              local_full_1,
  output logic              local_HP_input_req,
  output logic              local_LP_input_req,
  input  logic              local_HP_input_gnt,
  input  logic              local_LP_input_gnt,
`ifdef BINOC_NI_TRISTATE_EN
  output tri   [DATA_W-1:0] localPacket_0,
  output tri   [DATA_W-1:0] localPacket_1,
`else
  output logic [DATA_W-1:0] localPacket_0,
  output logic [DATA_W-1:0] localPacket_1,
`endif
  output logic              starve,
  output logic [15:0]       pkt_sent_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND
  } state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head_reg;
  logic [AW-1:0]     tail_reg;
  logic [CW-1:0]     count_reg;
  logic              core_ready_reg;
  logic [DATA_W-1:0] pkt0_reg;
  logic [DATA_W-1:0] pkt1_reg;
  logic [WW-1:0]     wait_reg;
  logic [15:0]       sent_reg;

  logic              push;
  logic              hp_req;
  logic              lp_req;
  logic              hp_hon;
  logic              lp_hon;
  logic              dual;
  logic [1:0]        pop_n;
  logic [AW-1:0]     head_nxt;
  logic [CW-1:0]     count_next;

  // Request generation: requests depend on the live full flags so a channel
  // that fills up drops its request in the same cycle. LP is only asked for
  // when there is a second packet to pair with HP, or when HP is blocked.
  always_comb begin
    push     = core_valid & core_ready_reg;
    hp_req   = (state_reg == ST_REQ) & ~local_full_0;
    lp_req   = (state_reg == ST_REQ) & ~local_full_1 &
               ((count_reg >= CW'(2)) | local_full_0);
    hp_hon   = hp_req & local_HP_input_gnt;
    lp_hon   = lp_req & local_LP_input_gnt;
    // Both grants with a single queued packet: HP takes it, LP grant is dropped.
    dual     = hp_hon & lp_hon & (count_reg >= CW'(2));
    pop_n    = dual ? 2'd2 : ((hp_hon | lp_hon) ? 2'd1 : 2'd0);
    head_nxt = head_reg + AW'(1);
    count_next = count_reg + CW'(push) - CW'(pop_n);
  end

  // FIFO storage write port; no reset so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_reg] <= core_packet;
    end
  end

  // Control: pointers, occupancy, FSM, registered packet outputs, counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      core_ready_reg <= 1'b1;
      pkt0_reg       <= '0;
      pkt1_reg       <= '0;
      wait_reg       <= '0;
      sent_reg       <= '0;
    end else begin
      head_reg       <= head_reg + AW'(pop_n);
      tail_reg       <= tail_reg + AW'(push);
      count_reg      <= count_next;
      core_ready_reg <= (count_next < CW'(DEPTH));
      sent_reg       <= sent_reg + 16'(pop_n);

      // Packets are shown for exactly the one SEND cycle after a grant.
      pkt0_reg <= '0;
      pkt1_reg <= '0;
      if (hp_hon) begin
        pkt0_reg <= mem[head_reg];
      end else if (lp_hon) begin
        pkt1_reg <= mem[head_reg];
      end
      if (dual) begin
        pkt1_reg <= mem[head_nxt];
      end

      if (hp_hon | lp_hon) begin
        wait_reg <= '0;
      end else if ((state_reg == ST_REQ) && (wait_reg != WW'(TIMEOUT))) begin
        wait_reg <= wait_reg + WW'(1);
      end

      unique case (state_reg)
        ST_IDLE: if (count_reg != '0) state_reg <= ST_REQ;
        ST_REQ:  if (hp_hon | lp_hon) state_reg <= ST_SEND;
        ST_SEND: state_reg <= (count_reg != '0) ? ST_REQ : ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef BINOC_NI_TRISTATE_EN
  logic pkt0_vld_reg;
  logic pkt1_vld_reg;

  // Drive-enable for the shared channel nets: active only in the SEND cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt0_vld_reg <= 1'b0;
      pkt1_vld_reg <= 1'b0;
    end else begin
      pkt0_vld_reg <= hp_hon;
      pkt1_vld_reg <= dual | (lp_hon & ~hp_hon);
    end
  end

  assign localPacket_0 = pkt0_vld_reg ? pkt0_reg : {DATA_W{1'bz}};
  assign localPacket_1 = pkt1_vld_reg ? pkt1_reg : {DATA_W{1'bz}};
`else
  assign localPacket_0 = pkt0_reg;
  assign localPacket_1 = pkt1_reg;
`endif

  assign core_ready         = core_ready_reg;
  assign local_HP_input_req = hp_req;
  assign local_LP_input_req = lp_req;
  assign starve             = (wait_reg == WW'(TIMEOUT));
  assign pkt_sent_cnt       = sent_reg;

endmodule
